// File: rtl/md_pkg.sv
// Shared encodings and defaults for the multiply/divide sequencer.
// Imported by md_arith and md_ctrl.
package md_pkg;

    typedef enum logic [2:0] {
        MD_MULT   = 3'd0,
        MD_MULTU  = 3'd1,
        MD_DIV    = 3'd2,
        MD_DIVU   = 3'd3,
        MD_MTHI   = 3'd4,
        MD_MTLO   = 3'd5,
        MD_RSVD6  = 3'd6,
        MD_RSVD7  = 3'd7
    } md_op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } md_state_e;

    localparam int unsigned MD_MULT_CYCLES_DEF = 5;
    localparam int unsigned MD_DIV_CYCLES_DEF  = 10;
    localparam int unsigned MD_CNT_W           = 4;

    // Multiply/divide ops occupy encodings 0..3; these are the ones that go busy.
    function automatic logic is_md_arith(input logic [2:0] op);
        return (op[2] == 1'b0);
    endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational 32x32 multiply and divide datapath producing HI/LO results.
// Divide by zero flags div_zero; the caller decides what to do with the result.
module md_arith
    import md_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div_zero
);

    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic        [31:0] abs_a;
    logic        [31:0] abs_b;
    logic        [31:0] num;
    logic        [31:0] den;
    logic        [31:0] quo;
    logic        [31:0] rem;
    logic               is_signed;

    assign prod_s    = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u    = {32'd0, a} * {32'd0, b};
    assign abs_a     = a[31] ? (~a + 32'd1) : a;
    assign abs_b     = b[31] ? (~b + 32'd1) : b;
    assign is_signed = (op == MD_DIV);
    assign div_zero  = ((op == MD_DIV) || (op == MD_DIVU)) && (b == 32'd0);

    // Signed divide works on magnitudes; 0x80000000 / -1 then falls out naturally.
    always_comb begin
        // NOTE: combinational blocks use blocking '=' so later lines see earlier results.
        num = is_signed ? abs_a : a;
        den = is_signed ? abs_b : b;
        if (den == 32'd0) begin
            den = 32'd1;
        end
        quo = num / den;
        rem = num % den;
    end

    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        res_hi = '0;
        res_lo = '0;
        case (md_op_e'(op))
            MD_MULT: begin
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
            end
            MD_MULTU: begin
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
            end
            MD_DIV: begin
                res_lo = (a[31] ^ b[31]) ? (~quo + 32'd1) : quo;
                res_hi = a[31] ? (~rem + 32'd1) : rem;
            end
            MD_DIVU: begin
                res_lo = quo;
                res_hi = rem;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/md_ctrl.sv
// Multiply/divide sequencer: owns HI/LO, runs fixed-latency mult/div, and
// requests ID stalls for md-class instructions while a result is pending.
module md_ctrl
    import md_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        d_uses_md,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        md_stall
);

    localparam logic [MD_CNT_W-1:0] MULT_CNT = MD_CNT_W'(MULT_CYCLES);
    localparam logic [MD_CNT_W-1:0] DIV_CNT  = MD_CNT_W'(DIV_CYCLES);

    md_state_e           state_q, state_d;
    logic [MD_CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]         pend_hi_q, pend_hi_d;
    logic [31:0]         pend_lo_q, pend_lo_d;
    logic                pend_wr_q, pend_wr_d;
    logic [31:0]         hi_q, hi_d;
    logic [31:0]         lo_q, lo_d;

    logic [31:0]         res_hi;
    logic [31:0]         res_lo;
    logic                div_zero;

    md_arith u_arith (
        .op       (md_op),
        .a        (rs_data),
        .b        (rt_data),
        .res_hi   (res_hi),
        .res_lo   (res_lo),
        .div_zero (div_zero)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (md_op_e'(md_op))
                        MD_MULT, MD_MULTU: begin
                            state_d   = S_RUN;
                            cnt_d     = MULT_CNT;
                            pend_hi_d = res_hi;
                            pend_lo_d = res_lo;
                            pend_wr_d = 1'b1;
                        end
                        MD_DIV, MD_DIVU: begin
                            state_d   = S_RUN;
                            cnt_d     = DIV_CNT;
                            pend_hi_d = res_hi;
                            pend_lo_d = res_lo;
                            // A zero divisor still occupies the unit but leaves HI/LO alone.
                            pend_wr_d = ~div_zero;
                        end
                        MD_MTHI: hi_d = rs_data;
                        MD_MTLO: lo_d = rs_data;
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                if (cnt_q <= MD_CNT_W'(1)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    if (pend_wr_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end else begin
                    cnt_d = cnt_q - MD_CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_wr_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            // NOTE: state registers use non-blocking '<=' so all flops update together.
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy     = (state_q == S_RUN);
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign md_stall = d_uses_md & (busy | (start & is_md_arith(md_op)));

endmodule

// File: tb/tb_md_ctrl.sv
// Self-checking bench for md_ctrl: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_md_ctrl;
    import md_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        d_uses_md;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        md_stall;

    always #5 clk = ~clk;

    md_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .md_op     (md_op),
        .rs_data   (rs_data),
        .rt_data   (rt_data),
        .d_uses_md (d_uses_md),
        .busy      (busy),
        .hi        (hi),
        .lo        (lo),
        .md_stall  (md_stall)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        wr;
    } mres_t;

    function automatic mres_t md_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        mres_t           r;
        longint          sa, sb, p, q, m;
        longint unsigned ua, ub, up, uq, um;
        r  = '0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            3'd0: begin p = sa * sb; r.hi = p[63:32]; r.lo = p[31:0]; r.wr = 1'b1; end
            3'd1: begin up = ua * ub; r.hi = up[63:32]; r.lo = up[31:0]; r.wr = 1'b1; end
            3'd2: if (b != 32'd0) begin
                q = sa / sb; m = sa % sb;
                r.lo = q[31:0]; r.hi = m[31:0]; r.wr = 1'b1;
            end
            3'd3: if (b != 32'd0) begin
                uq = ua / ub; um = ua % ub;
                r.lo = uq[31:0]; r.hi = um[31:0]; r.wr = 1'b1;
            end
            default: ;
        endcase
        return r;
    endfunction

    function automatic int op_cycles(input logic [2:0] op);
        if (op <= 3'd1) return 5;
        if (op <= 3'd3) return 10;
        return 0;
    endfunction

    int          m_left = 0;
    logic [31:0] m_hi   = '0;
    logic [31:0] m_lo   = '0;
    mres_t       m_pend = '0;

    always @(posedge clk) begin
        if (!reset) begin
            m_left <= 0;
            m_hi   <= '0;
            m_lo   <= '0;
            m_pend <= '0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1 && m_pend.wr) begin
                m_hi <= m_pend.hi;
                m_lo <= m_pend.lo;
            end
        end else if (start) begin
            if (md_op == 3'd4) m_hi <= rs_data;
            else if (md_op == 3'd5) m_lo <= rs_data;
            else if (md_op <= 3'd3) begin
                m_pend <= md_model(md_op, rs_data, rt_data);
                m_left <= op_cycles(md_op);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", 64'(busy), 64'(m_left > 0));
            check("hi", 64'(hi), 64'(m_hi));
            check("lo", 64'(lo), 64'(m_lo));
            check("md_stall", 64'(md_stall),
                  64'(d_uses_md & ((m_left > 0) | (start & (md_op <= 3'd3)))));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Issues one op now; returns busy cycles, stall cycles (incl. issue cycle)
    // and md_stall in the first non-busy cycle. Optionally injects an MTLO
    // while busy at loop index intrude_at.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int intrude_at, output int busy_cyc, output int stall_cyc,
                          output logic stall_end);
        bit done;
        start   = 1'b1;
        md_op   = op;
        rs_data = a;
        rt_data = b;
        #1;
        stall_cyc = int'(md_stall);
        busy_cyc  = 0;
        stall_end = 1'b0;
        done      = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            tick();
            start = 1'b0;
            if (k == intrude_at) begin
                start   = 1'b1;
                md_op   = MD_MTLO;
                rs_data = 32'h0000ABCD;
            end
            #1;
            if (!busy) begin
                done      = 1'b1;
                stall_end = md_stall;
            end else begin
                busy_cyc++;
                stall_cyc += int'(md_stall);
            end
        end
        check("op_timeout", 64'(done), 64'd1);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h80000000;
            2: return 32'hFFFFFFFF;
            3: return 32'h1;
            4: return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    int   bc, sc;
    logic se;

    initial begin
        reset = 1'b0; start = 1'b1; md_op = MD_DIV;
        rs_data = 32'd9; rt_data = 32'd3; d_uses_md = 1'b1;
        tick();
        chk_en = 1'b1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_stall_comb", 64'(md_stall), 64'd1);
        tick();
        check("rst_start_ignored", 64'(busy), 64'd0);
        reset = 1'b1; start = 1'b0; d_uses_md = 1'b0;
        tick();

        run_op(MD_MULT, 32'hFFFFFFFE, 32'd3, -1, bc, sc, se);
        check("mult_busy", 64'(bc), 64'd5);
        check("mult_hi", 64'(hi), 64'hFFFFFFFF);
        check("mult_lo", 64'(lo), 64'hFFFFFFFA);

        run_op(MD_MULTU, 32'hFFFFFFFF, 32'd2, -1, bc, sc, se);
        check("multu_busy", 64'(bc), 64'd5);
        check("multu_hi", 64'(hi), 64'h1);
        check("multu_lo", 64'(lo), 64'hFFFFFFFE);
        run_op(MD_DIV, 32'hFFFFFFF9, 32'd2, -1, bc, sc, se);
        check("div_b2b_busy", 64'(bc), 64'd10);
        check("div_lo", 64'(lo), 64'hFFFFFFFD);
        check("div_hi", 64'(hi), 64'hFFFFFFFF);

        run_op(MD_MTHI, 32'h11, 32'd0, -1, bc, sc, se);
        check("mthi_busy", 64'(bc), 64'd0);
        check("mthi_hi", 64'(hi), 64'h11);
        run_op(MD_MTLO, 32'h22, 32'd0, -1, bc, sc, se);
        check("mtlo_lo", 64'(lo), 64'h22);
        run_op(MD_DIVU, 32'd100, 32'd0, -1, bc, sc, se);
        check("divz_busy", 64'(bc), 64'd10);
        check("divz_hi", 64'(hi), 64'h11);
        check("divz_lo", 64'(lo), 64'h22);

        run_op(MD_DIV, 32'h80000000, 32'hFFFFFFFF, -1, bc, sc, se);
        check("divovf_lo", 64'(lo), 64'h80000000);
        check("divovf_hi", 64'(hi), 64'h0);

        run_op(MD_MULT, 32'd7, 32'd6, 1, bc, sc, se);
        check("intrude_busy", 64'(bc), 64'd5);
        check("intrude_lo", 64'(lo), 64'h2A);

        d_uses_md = 1'b1;
        run_op(MD_MULT, 32'd3, 32'd4, -1, bc, sc, se);
        check("stall_cycles", 64'(sc), 64'd6);
        check("stall_release", 64'(se), 64'd0);
        d_uses_md = 1'b0;

        // Reset in cycle t+3 of a DIV discards it.
        start = 1'b1; md_op = MD_DIV; rs_data = 32'd100; rt_data = 32'd7;
        tick();
        start = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_hi", 64'(hi), 64'd0);
        check("midrst_lo", 64'(lo), 64'd0);
        reset = 1'b1;
        repeat (15) tick();
        check("midrst_no_commit_hi", 64'(hi), 64'd0);
        check("midrst_no_commit_lo", 64'(lo), 64'd0);

        for (int i = 0; i < 4000; i++) begin
            tick();
            reset     = ($urandom_range(0, 199) != 0);
            start     = ($urandom_range(0, 2) == 0);
            md_op     = 3'($urandom_range(0, 7));
            rs_data   = pick();
            rt_data   = pick();
            d_uses_md = 1'($urandom_range(0, 1));
        end
        tick();
        reset = 1'b1; start = 1'b0;
        repeat (15) tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
